// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the two-master data bus arbiter: master identifiers,
// the lock-owner encoding and small helpers used by the top and the picker.
package data_bus_arbiter_pkg;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_DMA = 1'b1;

    // Lock owner record: valid=0 means no master holds the bus.
    typedef struct packed {
        logic valid;
        logic owner;
    } lock_t;

    localparam lock_t LOCK_NONE = 2'b00;

    // Build a held-lock record for the given master.
    function automatic lock_t make_lock(input logic owner);
        lock_t l;
        l.valid = 1'b1;
        l.owner = owner;
        return l;
    endfunction

    // One-hot grant vector for a single selected master.
    function automatic logic [1:0] onehot2(input logic sel);
        logic [1:0] g;
        if (sel == MASTER_DMA) begin
            g = 2'b10;
        end else begin
            g = 2'b01;
        end
        return g;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_arbiter2.sv
// Two-way picker: lone requester wins; on a tie an unexpired lock holder
// wins, otherwise the master that did not win last (or m0 in fixed mode).
module rr_arbiter2
    import data_bus_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] i_req,
    input  logic       i_last_winner,
    input  lock_t      i_lock,
    input  logic       i_burst_expired,
    output logic [1:0] o_grant
);

    // Combinational winner selection, at most one bit set.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01: o_grant = 2'b01;
            2'b10: o_grant = 2'b10;
            2'b11: begin
                if (i_lock.valid && !i_burst_expired) begin
                    o_grant = onehot2(i_lock.owner);
                end else if (FIXED_PRIO != 0) begin
                    o_grant = onehot2(MASTER_CPU);
                end else begin
                    o_grant = onehot2(~i_last_winner);
                end
            end
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one slave data port between the CPU (m0) and the DMA engine (m1).
// Same-cycle grant, read data routed back to the issuer one cycle later,
// bounded lock bursts with a one-idle-cycle grace period for the lock owner.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_lock,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_lock,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_rdata
);

    localparam int                STRB_W    = DATA_W / 8;
    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic             r_last_winner;
    lock_t            r_lock;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_idle;
    logic             r_rd_pend;
    logic             r_rd_tag;

    logic [1:0]        w_grant_raw;
    logic [1:0]        w_grant;
    logic              w_any_gnt;
    logic              w_winner;
    logic              w_win_lock;
    logic [STRB_W-1:0] w_win_strb;
    logic              w_burst_expired;

    assign w_burst_expired = (r_burst_cnt >= BURST_MAX);

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .i_req           ({m1_req, m0_req}),
        .i_last_winner   (r_last_winner),
        .i_lock          (r_lock),
        .i_burst_expired (w_burst_expired),
        .o_grant         (w_grant_raw)
    );

    // Suppress grants during reset and derive the winner's attributes.
    always_comb begin
        if (rst) begin
            w_grant = 2'b00;
        end else begin
            w_grant = w_grant_raw;
        end
        w_any_gnt  = |w_grant;
        w_winner   = w_grant[1];
        w_win_lock = w_grant[1] ? m1_lock  : m0_lock;
        w_win_strb = w_grant[1] ? m1_wstrb : m0_wstrb;
    end

    assign m0_gnt = w_grant[0];
    assign m1_gnt = w_grant[1];

    // Slave-side mux: winner drives the port; idle bus shows m0 with no strobes.
    always_comb begin
        if (w_grant[1]) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end else if (w_grant[0]) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = {STRB_W{1'b0}};
        end
    end

    // Pointer, lock owner, burst counter and idle grace tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_winner <= MASTER_CPU;
            r_lock        <= LOCK_NONE;
            r_burst_cnt   <= {CNT_W{1'b0}};
            r_idle        <= 1'b0;
        end else if (w_any_gnt) begin
            r_last_winner <= w_winner;
            r_idle        <= 1'b0;
            if (w_win_lock) begin
                r_lock <= make_lock(w_winner);
                if (r_lock.valid && (r_lock.owner == w_winner)) begin
                    r_burst_cnt <= w_burst_expired ? r_burst_cnt : r_burst_cnt + CNT_ONE;
                end else begin
                    r_burst_cnt <= CNT_ONE;
                end
            end else begin
                r_lock      <= LOCK_NONE;
                r_burst_cnt <= {CNT_W{1'b0}};
            end
        end else if (r_lock.valid) begin
            // Lock survives one idle cycle; a second one releases it.
            if (r_idle) begin
                r_lock      <= LOCK_NONE;
                r_burst_cnt <= {CNT_W{1'b0}};
                r_idle      <= 1'b0;
            end else begin
                r_idle <= 1'b1;
            end
        end else begin
            r_idle <= 1'b0;
        end
    end

    // Read-return tag: remember which master issued the granted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= MASTER_CPU;
        end else if (w_any_gnt && (w_win_strb == {STRB_W{1'b0}})) begin
            r_rd_pend <= 1'b1;
            r_rd_tag  <= w_winner;
        end else begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= r_rd_tag;
        end
    end

    // Route the returning read strobe to the tagged master only.
    always_comb begin
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        if (!rst && r_rd_pend) begin
            if (r_rd_tag == MASTER_DMA) begin
                m1_rvalid = 1'b1;
            end else begin
                m0_rvalid = 1'b1;
            end
        end else begin
            m0_rvalid = 1'b0;
            m1_rvalid = 1'b0;
        end
    end

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter (MAX_BURST=4, round-robin).
module tb_data_bus_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_lock = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0, m1_addr = 32'h0, m1_wdata = 32'h0;
    logic [3:0]  m0_wstrb = 4'h0, m1_wstrb = 4'h0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata = 32'h0;

    int chk_n = 0;
    int chk_pass = 0;

    // Reference model state (lock -1 = none).
    int          md_last = 0, md_lock = -1, md_cnt = 0, md_tag = 0;
    bit          md_idle = 1'b0, md_pend = 1'b0;
    logic [31:0] md_rdata = 32'h0;

    // Expected values for the current cycle.
    int          ew;
    logic        e_g0, e_g1, e_rv0, e_rv1;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_wdata, e_rdata;

    data_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB), .FIXED_PRIO(0)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slave_fn(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    // Slave memory model: data for the address presented one cycle earlier.
    always @(posedge clk) s_rdata <= slave_fn(s_addr);

    task automatic predict();
        ew = -1;
        if (!rst) begin
            if (m0_req && !m1_req) ew = 0;
            else if (m1_req && !m0_req) ew = 1;
            else if (m0_req && m1_req) ew = (md_lock >= 0 && md_cnt < MAXB) ? md_lock : 1 - md_last;
        end
        e_g0    = (ew == 0);
        e_g1    = (ew == 1);
        e_strb  = (ew == 0) ? m0_wstrb : (ew == 1) ? m1_wstrb : 4'h0;
        e_addr  = (ew == 1) ? m1_addr  : m0_addr;
        e_wdata = (ew == 1) ? m1_wdata : m0_wdata;
        e_rv0   = !rst && md_pend && (md_tag == 0);
        e_rv1   = !rst && md_pend && (md_tag == 1);
        e_rdata = md_rdata;
    endtask

    task automatic commit();
        if (rst) begin
            md_last = 0; md_lock = -1; md_cnt = 0; md_idle = 1'b0; md_pend = 1'b0;
        end else if (ew >= 0) begin
            logic lk;
            lk = (ew == 1) ? m1_lock : m0_lock;
            md_last = ew;
            md_idle = 1'b0;
            if (lk) begin
                md_cnt  = (md_lock == ew) ? ((md_cnt + 1 > MAXB) ? MAXB : md_cnt + 1) : 1;
                md_lock = ew;
            end else begin
                md_lock = -1; md_cnt = 0;
            end
            md_pend  = (e_strb == 4'h0);
            md_tag   = ew;
            md_rdata = slave_fn(e_addr);
        end else begin
            md_pend = 1'b0;
            if (md_lock >= 0) begin
                if (md_idle) begin md_lock = -1; md_cnt = 0; md_idle = 1'b0; end
                else md_idle = 1'b1;
            end
        end
    endtask

    task automatic apply(input logic r,
                         input logic q0, l0, input logic [31:0] a0, d0, input logic [3:0] s0,
                         input logic q1, l1, input logic [31:0] a1, d1, input logic [3:0] s1);
        @(negedge clk);
        rst = r;
        m0_req = q0; m0_lock = l0; m0_addr = a0; m0_wdata = d0; m0_wstrb = s0;
        m1_req = q1; m1_lock = l1; m1_addr = a1; m1_wdata = d1; m1_wstrb = s1;
        #1;
        predict();
        commit();
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b0, 32'h10, 32'h1, 4'hF, 1'b1, 1'b0, 32'h20, 32'h2, 4'hF);
            chk_n++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_wstrb} !== 8'h00)
                $display("FAIL reset_outputs cycle %0d: got %b want 00000000", i,
                         {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_wstrb});
            else chk_pass++;
        end
    endtask

    task automatic test_lone_read();
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk_n++;
        if ({m1_gnt, m0_gnt, s_wstrb} !== 6'b01_0000 || s_addr !== 32'h0000_0040)
            $display("FAIL lone_grant: got gnt=%b strb=%h addr=%h want gnt=01 strb=0 addr=00000040",
                     {m1_gnt, m0_gnt}, s_wstrb, s_addr);
        else chk_pass++;
        idle();
        chk_n++;
        if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF)
            $display("FAIL lone_return: got rv0=%b rv1=%b rdata=%h want 1 0 deadbeef",
                     m0_rvalid, m1_rvalid, m0_rdata);
        else chk_pass++;
    endtask

    task automatic test_contention();
        logic [1:0]  want;
        logic [31:0] prev_addr;
        int          prev_w;
        do_reset();
        prev_w = -1;
        prev_addr = 32'h0;
        for (int i = 0; i < 7; i++) begin
            if (i < 6) apply(1'b0, 1'b1, 1'b0, 32'h100 + 32'(i), 32'h0, 4'h0,
                                   1'b1, 1'b0, 32'h200 + 32'(i), 32'h0, 4'h0);
            else idle();
            if (i < 6) begin
                want = (i % 2 == 0) ? 2'b10 : 2'b01;
                chk_n++;
                if ({m1_gnt, m0_gnt} !== want)
                    $display("FAIL contention_grant %0d: got %b want %b", i, {m1_gnt, m0_gnt}, want);
                else chk_pass++;
            end
            if (prev_w >= 0) begin
                chk_n++;
                if (m0_rvalid !== (prev_w == 0) || m1_rvalid !== (prev_w == 1) ||
                    (prev_w == 0 ? m0_rdata : m1_rdata) !== slave_fn(prev_addr))
                    $display("FAIL contention_return %0d: got rv=%b%b rdata=%h want tag %0d data %h",
                             i, m1_rvalid, m0_rvalid, (prev_w == 0 ? m0_rdata : m1_rdata),
                             prev_w, slave_fn(prev_addr));
                else chk_pass++;
            end
            if (i < 6) begin
                prev_w = (i % 2 == 0) ? 1 : 0;
                prev_addr = (prev_w == 1) ? 32'h200 + 32'(i) : 32'h100 + 32'(i);
            end
        end
    endtask

    task automatic test_burst_cap();
        logic [31:0] a1;
        logic [1:0]  want;
        do_reset();
        a1 = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b1, 1'b1, a1, 32'hA000 + 32'(i), 4'hF);
            want = (i < 4) ? 2'b10 : 2'b01;
            chk_n++;
            if ({m1_gnt, m0_gnt} !== want || s_wstrb !== ((i < 4) ? 4'hF : 4'h0))
                $display("FAIL burst_cap %0d: got gnt=%b strb=%h want gnt=%b", i, {m1_gnt, m0_gnt}, s_wstrb, want);
            else chk_pass++;
            if (m1_gnt) a1 = a1 + 32'd4;
        end
    endtask

    task automatic test_lock_no_competitor();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h4000_0000 + 32'(4 * i), 32'(i), 4'hF);
            chk_n++;
            if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0)
                $display("FAIL lock_alone %0d: got gnt=%b%b want 10", i, m1_gnt, m0_gnt);
            else chk_pass++;
        end
        apply(1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 1'b1, 1'b1, 32'h4000_0028, 32'h0, 4'hF);
        chk_n++;
        if ({m1_gnt, m0_gnt} !== 2'b01)
            $display("FAIL lock_saturated: got gnt=%b want 01", {m1_gnt, m0_gnt});
        else chk_pass++;
    endtask

    task automatic test_idle_grace();
        logic [1:0] want;
        for (int n = 1; n <= 2; n++) begin
            do_reset();
            for (int i = 0; i < 2; i++)
                apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h600, 32'h0, 4'h3);
            for (int i = 0; i < n; i++) idle();
            apply(1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0, 1'b1, 1'b1, 32'h604, 32'h0, 4'h3);
            want = (n == 1) ? 2'b10 : 2'b01;
            chk_n++;
            if ({m1_gnt, m0_gnt} !== want || s_wstrb !== ((n == 1) ? 4'h3 : 4'h0))
                $display("FAIL idle_grace %0d: got gnt=%b strb=%h want gnt=%b", n, {m1_gnt, m0_gnt}, s_wstrb, want);
            else chk_pass++;
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk_n++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0)
            $display("FAIL rst_mid_read_drop: got rv=%b%b want 00", m1_rvalid, m0_rvalid);
        else chk_pass++;
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h900, 32'h0, 4'h0);
        chk_n++;
        if (m1_gnt !== 1'b1 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0)
            $display("FAIL rst_mid_read_after: got gnt1=%b rv=%b%b want 1 00", m1_gnt, m1_rvalid, m0_rvalid);
        else chk_pass++;
    endtask

    task automatic test_random();
        bit          tv[2];
        logic        tl[2];
        logic [31:0] ta[2], td[2];
        logic [3:0]  ts[2];
        logic        q[2];
        logic        r;
        int          bad;
        do_reset();
        tv[0] = 1'b0; tv[1] = 1'b0;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!tv[m] && $urandom_range(99) < 60) begin
                    tv[m] = 1'b1;
                    tl[m] = $urandom_range(1) == 1;
                    ta[m] = {$urandom_range(65535), 2'b00} & 32'hFFFF_FFFC;
                    td[m] = $urandom;
                    ts[m] = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0;
                end else if (tv[m] && $urandom_range(99) < 8) begin
                    tv[m] = 1'b0;
                end
                q[m] = tv[m];
            end
            r = ($urandom_range(99) < 2);
            apply(r, q[0], tl[0], ta[0], td[0], ts[0], q[1], tl[1], ta[1], td[1], ts[1]);
            chk_n++;
            if (m0_gnt !== e_g0 || m1_gnt !== e_g1 || s_wstrb !== e_strb ||
                s_addr !== e_addr || s_wdata !== e_wdata || m0_rvalid !== e_rv0 || m1_rvalid !== e_rv1 ||
                (e_rv0 && m0_rdata !== e_rdata) || (e_rv1 && m1_rdata !== e_rdata)) begin
                if (bad < 10)
                    $display("FAIL random %0d: got gnt=%b%b strb=%h addr=%h rv=%b%b want gnt=%b%b strb=%h addr=%h rv=%b%b",
                             c, m1_gnt, m0_gnt, s_wstrb, s_addr, m1_rvalid, m0_rvalid,
                             e_g1, e_g0, e_strb, e_addr, e_rv1, e_rv0);
                bad++;
            end else chk_pass++;
            if (ew >= 0) tv[ew] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_lone_read();
        test_contention();
        test_burst_cap();
        test_lock_no_competitor();
        test_idle_grace();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", chk_pass, chk_n);
        $finish;
    end

endmodule
